// File: rtl/led_trail_driver.sv
// Comet-style LED trail driver: lit position at full brightness, linear PWM fade behind it.
// Optional square-law gamma on the PWM duty when LED_TRAIL_GAMMA_EN is defined.
module led_trail_driver #(
    parameter int N_LEDS    = 8,
    parameter int PWM_BITS  = 4,
    parameter int DECAY_DIV = 1000,
    localparam int PW       = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PW-1:0]     pos,
    output logic [N_LEDS-1:0] led,
    output logic              trail_active
);

    localparam int SW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [SW-1:0] PS_LAST = SW'(DECAY_DIV - 1);

    logic [SW-1:0]       prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] bright     [N_LEDS];
    logic [PWM_BITS-1:0] bright_nxt [N_LEDS];
    logic [N_LEDS-1:0]   led_nxt;
    logic                tick;
    logic                trail_nxt;

    function automatic logic [PWM_BITS-1:0] duty(input logic [PWM_BITS-1:0] b);
`ifdef LED_TRAIL_GAMMA_EN
        logic [2*PWM_BITS-1:0] w;
        w = {{PWM_BITS{1'b0}}, b};
        return PWM_BITS'((w * w) >> PWM_BITS);
`else
        return b;
`endif
    endfunction

    always_comb tick = (prescaler == PS_LAST);

    // The current position wins over decay, even on a tick cycle.
    always_comb begin
        led_nxt   = '0;
        trail_nxt = 1'b0;
        for (int i = 0; i < N_LEDS; i++) begin
            bright_nxt[i] = bright[i];
            led_nxt[i] = (bright[i] == MAX) || (duty(bright[i]) > pwm_cnt);
            if (pos == PW'(i))
                bright_nxt[i] = MAX;
            else if (tick && bright[i] != '0)
                bright_nxt[i] = bright[i] - 1'b1;
            if (pos != PW'(i) && bright_nxt[i] != '0)
                trail_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            led          <= '0;
            trail_active <= 1'b0;
            for (int i = 0; i < N_LEDS; i++)
                bright[i] <= '0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            pwm_cnt      <= pwm_cnt + 1'b1;
            led          <= led_nxt;
            trail_active <= trail_nxt;
            for (int i = 0; i < N_LEDS; i++)
                bright[i] <= bright_nxt[i];
        end
    end

endmodule

// File: tb/tb_led_trail_driver.sv
// Bench for led_trail_driver: three instances stepped in lockstep against a
// per-edge brightness model (8 LEDs / div 4, 5 LEDs / div 4, 8 LEDs / div 64).
module tb_led_trail_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] pos_a = '0, pos_b = '0, pos_c = '0;
    logic [7:0] led_a, led_c;
    logic [4:0] led_b;
    logic       trail_a, trail_b, trail_c;

    int n_assert = 0;
    int n_fail = 0;

    int         mb [3][8];
    int         mc [3];
    logic [7:0] ml [3];
    logic       mt [3];

    led_trail_driver #(.N_LEDS(8), .PWM_BITS(4), .DECAY_DIV(4)) u_a (
        .clk(clk), .reset(reset), .pos(pos_a), .led(led_a), .trail_active(trail_a));
    led_trail_driver #(.N_LEDS(5), .PWM_BITS(4), .DECAY_DIV(4)) u_b (
        .clk(clk), .reset(reset), .pos(pos_b), .led(led_b), .trail_active(trail_b));
    led_trail_driver #(.N_LEDS(8), .PWM_BITS(4), .DECAY_DIV(64)) u_c (
        .clk(clk), .reset(reset), .pos(pos_c), .led(led_c), .trail_active(trail_c));

    always #5 clk = ~clk;

    function automatic int duty(input int b);
`ifdef LED_TRAIL_GAMMA_EN
        return (b * b) / 16;
`else
        return b;
`endif
    endfunction

    task automatic mreset();
        for (int k = 0; k < 3; k++) begin
            mc[k] = 0;
            ml[k] = '0;
            mt[k] = 1'b0;
            for (int i = 0; i < 8; i++) mb[k][i] = 0;
        end
    endtask

    // Edge number c since reset release fixes both prescaler and PWM phase.
    task automatic mdl(input int k, input int n, input int d, input int p);
        int  c;
        bit  tk;
        c  = mc[k];
        tk = (c % d) == d - 1;
        for (int i = 0; i < n; i++)
            ml[k][i] = (mb[k][i] == 15) || (duty(mb[k][i]) > c % 16);
        for (int i = 0; i < n; i++) begin
            if (i == p) mb[k][i] = 15;
            else if (tk && mb[k][i] > 0) mb[k][i] = mb[k][i] - 1;
        end
        mt[k] = 1'b0;
        for (int i = 0; i < n; i++)
            if (i != p && mb[k][i] != 0) mt[k] = 1'b1;
        mc[k] = c + 1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int pa, input int pb, input int pc);
        pos_a = 3'(pa);
        pos_b = 3'(pb);
        pos_c = 3'(pc);
        @(posedge clk);
        mdl(0, 8, 4, pa);
        mdl(1, 5, 4, pb);
        mdl(2, 8, 64, pc);
        #1;
        chk("led_a", led_a, ml[0]);
        chk("trail_a", {7'b0, trail_a}, {7'b0, mt[0]});
        chk("led_b", {3'b0, led_b}, ml[1]);
        chk("trail_b", {7'b0, trail_b}, {7'b0, mt[1]});
        chk("led_c", led_c, ml[2]);
        chk("trail_c", {7'b0, trail_c}, {7'b0, mt[2]});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_led_a"}, led_a, 8'h00);
        chk({tag, "_trail_a"}, {7'b0, trail_a}, 8'h00);
        chk({tag, "_led_b"}, {3'b0, led_b}, 8'h00);
        chk({tag, "_led_c"}, led_c, 8'h00);
    endtask

    initial begin
        int cnt;
        int guard;
        int pa, pb, len;
        mreset();

        // Reset held for three edges, then released with pos=3.
        pos_a = 3'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_zero("rst");
        end
        #2 reset = 1'b1;
        step(3, 0, 0);
        chk("first_edge_led", led_a, 8'h00);
        step(3, 0, 0);
        chk("second_edge_led", led_a, 8'h08);
        for (int i = 0; i < 68; i++) step(3, 0, 0);

        // Move to 4: lit two edges later, LED 3 fades over 60 cycles.
        step(4, 0, 0);
        step(4, 0, 0);
        chk("led4_on", {7'b0, led_a[4]}, 8'h01);
        chk("trail_during_fade", {7'b0, trail_a}, 8'h01);
        for (int i = 0; i < 64; i++) step(4, 0, 0);
        chk("trail_after_fade", {7'b0, trail_a}, 8'h00);
        chk("led_after_fade", led_a, 8'h10);

        // Return to a decaying LED exactly on a tick edge.
        for (int i = 0; i < 5; i++) step(3, 0, 0);
        for (int i = 0; i < 6; i++) step(4, 0, 0);
        guard = 0;
        while ((mc[0] % 4) != 3 && guard < 8) begin
            step(4, 0, 0);
            guard++;
        end
        step(3, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(3, 0, 0);
            chk("return_steady", {7'b0, led_a[3]}, 8'h01);
        end

        // Asynchronous reset in the middle of a fade.
        for (int i = 0; i < 10; i++) step(6, 2, 0);
        #2 reset = 1'b0;
        #1;
        chk_zero("async_rst");
        chk("async_rst_trail_b", {7'b0, trail_b}, 8'h00);
        mreset();
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) step(5, 0, 0);
        chk("no_residual", led_a, 8'h20);
        chk("no_residual_trail", {7'b0, trail_a}, 8'h00);

        // Random position walk on both small-divider instances.
        for (int s = 0; s < 40; s++) begin
            pa  = int'($urandom_range(0, 7));
            pb  = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) step(pa, pb, 0);
        end

        // Out-of-range position on the 5-LED instance.
        for (int i = 0; i < 20; i++) step(0, 2, 0);
        for (int i = 0; i < 80; i++) step(0, 6, 0);
        chk("oor_led", {3'b0, led_b}, 8'h00);
        chk("oor_trail", {7'b0, trail_b}, 8'h00);

        // Duty cycle at full and half brightness on the slow instance.
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0);
            cnt += int'(led_c[0]);
        end
        chk("duty_15", 8'(cnt), 8'd16);
        guard = 0;
        while (mb[2][0] != 8 && guard < 1000) begin
            step(0, 0, 7);
            guard++;
        end
        chk("reach_8_timeout", 8'(guard < 1000), 8'd1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 7);
            cnt += int'(led_c[0]);
        end
`ifdef LED_TRAIL_GAMMA_EN
        chk("duty_8", 8'(cnt), 8'd4);
`else
        chk("duty_8", 8'(cnt), 8'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
